// File: rtl/teamplayer_if.sv
// Host-side pin bundle for one Genesis controller port.
// port_in/port_dir come from the I/O port model, port_out returns the
// pin levels the host sees.
interface teamplayer_if;
    logic [6:0] port_in;
    logic [6:0] port_dir;
    logic [6:0] port_out;

    modport master (output port_in, output port_dir, input port_out);
    modport slave  (input port_in, input port_dir, output port_out);
endinterface

// File: rtl/teamplayer_ctrl.sv
// Sega Team Player 4-port adapter emulation on one controller port.
// Streams a header, four type nibbles and the data nibbles of every
// connected pad using the TH/TR request and TL acknowledge handshake.
// Optional build macro TEAMPLAYER_SNAPSHOT_EN: latch all four pads at the
// start of a transfer instead of sampling them live per nibble.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | TH high / no transfer, D=0x3, TL=1, waiting for TH falling edge
// XFER  | transfer running, each TR edge advances k after ACK_DELAY clks
// ABORT | TR went quiet for TIMEOUT clks, D=0xF, TL=1 until TH rises
module teamplayer_ctrl #(
    parameter int unsigned TIMEOUT   = 855000,
    parameter int unsigned ACK_DELAY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [11:0]  pad1,
    input  logic [11:0]  pad2,
    input  logic [11:0]  pad3,
    input  logic [11:0]  pad4,
    input  logic [7:0]   pad_type,
    teamplayer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

    localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);
    localparam logic [3:0]  ACK_LOAD  = 4'(ACK_DELAY - 1);
    // Longest sequence is 20 nibbles; k parks here once past the end.
    localparam logic [4:0]  K_PARK    = 5'd21;

    state_t      state_q;
    logic [4:0]  k_q;
    logic [4:0]  k_next;
    logic [23:0] timer_q;
    logic [3:0]  dly_cnt_q;
    logic        dly_pend_q;
    logic        tl_pend_q;
    logic [3:0]  d_q;
    logic        tl_q;
    logic [7:0]  types_q;
    logic [3:0]  nib_next;

    logic th_raw, tr_raw;
    logic th_s1, th_s2, th_d;
    logic tr_s1, tr_s2, tr_d;
    logic th_fall, th_rise, tr_edge;

    logic [11:0] src [4];

    assign th_raw = bus.port_dir[6] ? bus.port_in[6] : 1'b1;
    assign tr_raw = bus.port_dir[5] ? bus.port_in[5] : 1'b1;

    assign th_fall = th_d & ~th_s2;
    assign th_rise = ~th_d & th_s2;
    assign tr_edge = tr_d ^ tr_s2;

    // Pins the host does not drive show the adapter's levels.
    assign bus.port_out = (bus.port_dir & bus.port_in) |
                          (~bus.port_dir & {2'b11, tl_q, d_q});

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            th_s1 <= 1'b1;
            th_s2 <= 1'b1;
            th_d  <= 1'b1;
            tr_s1 <= 1'b1;
            tr_s2 <= 1'b1;
            tr_d  <= 1'b1;
        end else begin
            th_s1 <= th_raw;
            th_s2 <= th_s1;
            th_d  <= th_s2;
            tr_s1 <= tr_raw;
            tr_s2 <= tr_s1;
            tr_d  <= tr_s2;
        end
    end

`ifdef TEAMPLAYER_SNAPSHOT_EN
    logic [11:0] snap [4];

    // Freeze all pads when a transfer starts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) snap[i] <= '0;
        end else if (state_q == IDLE && th_fall) begin
            snap[0] <= pad1;
            snap[1] <= pad2;
            snap[2] <= pad3;
            snap[3] <= pad4;
        end
    end

    assign src[0] = snap[0];
    assign src[1] = snap[1];
    assign src[2] = snap[2];
    assign src[3] = snap[3];
`else
    assign src[0] = pad1;
    assign src[1] = pad2;
    assign src[2] = pad3;
    assign src[3] = pad4;
`endif

    function automatic logic [3:0] type_nib(input logic [1:0] t);
        case (t)
            2'd1:    type_nib = 4'h0;
            2'd2:    type_nib = 4'h1;
            default: type_nib = 4'hF;
        endcase
    endfunction

    function automatic logic [4:0] pad_len(input logic [1:0] t);
        case (t)
            2'd1:    pad_len = 5'd2;
            2'd2:    pad_len = 5'd3;
            default: pad_len = 5'd0;
        endcase
    endfunction

    // Packing is {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}, active-high in, active-low out.
    function automatic logic [3:0] data_nib(input logic [11:0] p, input logic [1:0] sel);
        case (sel)
            2'd0:    data_nib = ~p[3:0];
            2'd1:    data_nib = ~{p[7], p[4], p[6], p[5]};
            default: data_nib = ~{p[8], p[9], p[10], p[11]};
        endcase
    endfunction

    assign k_next = (k_q >= K_PARK) ? k_q : k_q + 5'd1;

    // Nibble that will be presented once the pending TR step completes.
    always_comb begin
        logic [4:0] base;
        logic [4:0] len;
        nib_next = 4'hF;
        base     = 5'd8;
        len      = 5'd0;
        if (k_next < 5'd4) begin
            case (k_next[1:0])
                2'd0:    nib_next = 4'h3;
                2'd1:    nib_next = 4'hF;
                default: nib_next = 4'h0;
            endcase
        end else if (k_next < 5'd8) begin
            case (k_next[1:0])
                2'd0:    nib_next = type_nib(types_q[1:0]);
                2'd1:    nib_next = type_nib(types_q[3:2]);
                2'd2:    nib_next = type_nib(types_q[5:4]);
                default: nib_next = type_nib(types_q[7:6]);
            endcase
        end else begin
            for (int p = 0; p < 4; p++) begin
                len = pad_len(types_q[2*p +: 2]);
                if (k_next >= base && k_next < base + len)
                    nib_next = data_nib(src[p], 2'(k_next - base));
                base = base + len;
            end
        end
    end

    // Transfer sequencer: TH framing, delayed TR acknowledge, timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            timer_q    <= '0;
            dly_cnt_q  <= '0;
            dly_pend_q <= 1'b0;
            tl_pend_q  <= 1'b1;
            d_q        <= 4'h3;
            tl_q       <= 1'b1;
            types_q    <= '0;
        end else if (th_rise) begin
            state_q    <= IDLE;
            k_q        <= '0;
            timer_q    <= '0;
            dly_cnt_q  <= '0;
            dly_pend_q <= 1'b0;
            d_q        <= 4'h3;
            tl_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    k_q        <= '0;
                    timer_q    <= '0;
                    dly_cnt_q  <= '0;
                    dly_pend_q <= 1'b0;
                    d_q        <= 4'h3;
                    tl_q       <= 1'b1;
                    if (th_fall) begin
                        state_q <= XFER;
                        types_q <= pad_type;
                    end
                end
                XFER: begin
                    if (timer_q == TIMEOUT_C) begin
                        state_q    <= ABORT;
                        d_q        <= 4'hF;
                        tl_q       <= 1'b1;
                        dly_pend_q <= 1'b0;
                        dly_cnt_q  <= '0;
                    end else if (tr_edge) begin
                        // A new edge restarts the count and drops any pending step.
                        timer_q    <= '0;
                        dly_pend_q <= 1'b1;
                        dly_cnt_q  <= ACK_LOAD;
                        tl_pend_q  <= tr_s2;
                    end else begin
                        if (timer_q != 24'hFF_FFFF)
                            timer_q <= timer_q + 24'd1;
                        if (dly_pend_q) begin
                            if (dly_cnt_q == 4'd0) begin
                                dly_pend_q <= 1'b0;
                                k_q        <= k_next;
                                d_q        <= nib_next;
                                tl_q       <= tl_pend_q;
                            end else begin
                                dly_cnt_q <= dly_cnt_q - 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    d_q        <= 4'hF;
                    tl_q       <= 1'b1;
                    dly_pend_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_teamplayer_ctrl.sv
// Directed bench for teamplayer_ctrl: expected pin levels are queued when
// stimulus is applied and popped when the port is sampled.
module tb_teamplayer_ctrl;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] pad1 = '0, pad2 = '0, pad3 = '0, pad4 = '0;
    logic [7:0]  pad_type = '0;
    logic        th = 1'b1;
    logic        tr = 1'b1;

    int total = 0;
    int bad   = 0;
    int kk    = 0;

    logic [6:0] sb [$];
    logic [3:0] seq [$];

    teamplayer_if bus ();

    teamplayer_ctrl #(.TIMEOUT(TO), .ACK_DELAY(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pad1     (pad1),
        .pad2     (pad2),
        .pad3     (pad3),
        .pad4     (pad4),
        .pad_type (pad_type),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag);
        logic [6:0] e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s got=%h exp=<empty scoreboard>", tag, bus.port_out);
        end else begin
            e = sb.pop_front();
            assert (bus.port_out === e) else begin
                bad++;
                $error("FAIL %s got=%h exp=%h", tag, bus.port_out, e);
            end
        end
    endtask

    task automatic expect_now(input logic [3:0] d, input logic tl, input int wait_n, input string tag);
        sb.push_back({th, tr, tl, d});
        tick(wait_n);
        check(tag);
    endtask

    task automatic set_th(input logic v);
        th = v;
        bus.port_in[6] = v;
        if (!v) kk = 0;
    endtask

    // Expected nibble list straight from the adapter's documented protocol.
    task automatic build_seq(input logic [7:0] pt, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d);
        logic [1:0]  t;
        logic [11:0] p;
        seq.delete();
        seq.push_back(4'h3); seq.push_back(4'hF); seq.push_back(4'h0); seq.push_back(4'h0);
        for (int i = 0; i < 4; i++) begin
            t = pt[2*i +: 2];
            seq.push_back(t == 2'd1 ? 4'h0 : (t == 2'd2 ? 4'h1 : 4'hF));
        end
        for (int i = 0; i < 4; i++) begin
            t = pt[2*i +: 2];
            p = (i == 0) ? a : (i == 1) ? b : (i == 2) ? c : d;
            if (t == 2'd1 || t == 2'd2) begin
                seq.push_back(~{p[3], p[2], p[1], p[0]});
                seq.push_back(~{p[7], p[4], p[6], p[5]});
                if (t == 2'd2) seq.push_back(~{p[8], p[9], p[10], p[11]});
            end
        end
    endtask

    // One TR toggle: expect the next list nibble and TL following TR.
    task automatic tr_step(input string tag);
        logic [3:0] nib;
        tr = ~tr;
        bus.port_in[5] = tr;
        kk++;
        nib = (kk < seq.size()) ? seq[kk] : 4'hF;
        expect_now(nib, tr, 8, tag);
    endtask

    initial begin
        bus.port_in  = 7'h00;
        bus.port_dir = 7'h00;

        // reset: undriven pins read 0x73
        sb.push_back(7'h73);
        tick(2);
        check("reset_out");
        reset_n = 1'b1;
        sb.push_back(7'h73);
        tick(2);
        check("post_reset");

        // full read, P1 6-button, P2 3-button, P3/P4 none
        bus.port_dir = 7'h60;
        bus.port_in  = 7'h60;
        pad_type = 8'h06;
        pad1 = 12'h001;
        pad2 = 12'h040;
        expect_now(4'h3, 1'b1, 6, "idle_dir");
        build_seq(8'h06, pad1, pad2, pad3, pad4);
        set_th(1'b0);
        tick(6);
        pad_type = 8'hFF;
        expect_now(4'h3, 1'b1, 1, "th_fall");
        for (int i = 0; i < 13; i++) tr_step("full_read");

        // timeout
        set_th(1'b1);
        expect_now(4'h3, 1'b1, 6, "to_idle");
        set_th(1'b0);
        expect_now(4'h3, 1'b1, TO / 2, "to_wait");
        expect_now(4'hF, 1'b1, TO, "to_abort");
        tr = ~tr; bus.port_in[5] = tr;
        expect_now(4'hF, 1'b1, 8, "to_ignore1");
        tr = ~tr; bus.port_in[5] = tr;
        expect_now(4'hF, 1'b1, 8, "to_ignore2");
        set_th(1'b1);
        expect_now(4'h3, 1'b1, 6, "to_exit");

        // abort mid-transfer and restart
        pad_type = 8'h06;
        build_seq(8'h06, pad1, pad2, pad3, pad4);
        set_th(1'b0);
        expect_now(4'h3, 1'b1, 6, "ab_start");
        for (int i = 0; i < 5; i++) tr_step("ab_steps");
        set_th(1'b1);
        expect_now(4'h3, 1'b1, 6, "ab_idle");
        set_th(1'b0);
        expect_now(4'h3, 1'b1, 6, "ab_restart");
        tr_step("ab_first");
        set_th(1'b1);
        tick(6);

        // overrun with no pads connected
        pad_type = 8'hFF;
        build_seq(8'hFF, pad1, pad2, pad3, pad4);
        set_th(1'b0);
        expect_now(4'h3, 1'b1, 6, "ov_start");
        for (int i = 0; i < 10; i++) tr_step("overrun");
        set_th(1'b1);
        tick(6);

        // pad released after TH fall, before its data nibble
        pad_type = 8'h02;
        pad1 = 12'h001;
        build_seq(8'h02, pad1, pad2, pad3, pad4);
        set_th(1'b0);
        expect_now(4'h3, 1'b1, 6, "snap_start");
        pad1 = 12'h000;
`ifndef TEAMPLAYER_SNAPSHOT_EN
        build_seq(8'h02, pad1, pad2, pad3, pad4);
`endif
        for (int i = 0; i < 9; i++) tr_step("snap_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
